// File: rtl/dbus_ram_bridge_if.sv
// Bundle of CPU data-bus command/response and RAM port signals for dbus_ram_bridge.
// The bridge connects through the slave modport; the CPU and RAM side connects through master.
interface dbus_ram_bridge_if #(
  parameter int ADDR_WIDTH = 16
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [1:0]            cmd_size;
  logic                  cmd_unsigned;
  logic [31:0]           cmd_data;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic                  rsp_error;

  logic                  ram_wr_en;
  logic [3:0]            ram_wr_mask;
  logic [ADDR_WIDTH-3:0] ram_wr_addr;
  logic [31:0]           ram_wr_data;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-3:0] ram_rd_addr;
  logic [31:0]           ram_rd_data;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_unsigned, cmd_data,
    input  rsp_ready, ram_rd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_error,
    output ram_wr_en, ram_wr_mask, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_unsigned, cmd_data,
    output rsp_ready, ram_rd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error,
    input  ram_wr_en, ram_wr_mask, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr
  );
endinterface

// File: rtl/dbus_ram_bridge.sv
// Bridges a single-outstanding CPU load/store bus onto a synchronous-read RAM with byte-mask writes.
// Stores and rejected commands respond one cycle after acceptance; loads respond after two.
module dbus_ram_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            resetn,
  dbus_ram_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q;
  logic                  rsp_valid_q;
  logic                  rsp_error_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;

  logic                  fire;
  logic                  bad;
  logic [1:0]            off;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_val_d;

  assign off           = bus.cmd_addr[1:0];
  assign bus.cmd_ready = (state_q == IDLE);
  // Gating with resetn keeps both RAM enables low while reset is held.
  assign fire          = bus.cmd_valid & bus.cmd_ready & resetn;

  always_comb begin
    bad = 1'b0;
    case (bus.cmd_size)
      2'd1:    bad = off[0];
      2'd2:    bad = (off != 2'd0);
      2'd3:    bad = 1'b1;
      default: bad = 1'b0;
    endcase
  end

  assign bus.ram_wr_en   = fire & bus.cmd_write & ~bad;
  assign bus.ram_rd_en   = fire & ~bus.cmd_write & ~bad;
  assign bus.ram_wr_addr = bus.cmd_addr[ADDR_WIDTH-1:2];
  assign bus.ram_rd_addr = bus.cmd_addr[ADDR_WIDTH-1:2];

  always_comb begin
    bus.ram_wr_mask = 4'b1111;
    bus.ram_wr_data = bus.cmd_data;
    case (bus.cmd_size)
      2'd0: begin
        bus.ram_wr_mask = 4'b0001 << off;
        bus.ram_wr_data = {4{bus.cmd_data[7:0]}};
      end
      2'd1: begin
        bus.ram_wr_mask = 4'b0011 << off;
        bus.ram_wr_data = {2{bus.cmd_data[15:0]}};
      end
      default: begin
        bus.ram_wr_mask = 4'b1111;
        bus.ram_wr_data = bus.cmd_data;
      end
    endcase
  end

  // Lane selection uses the offset captured at acceptance, since cmd_addr may change meanwhile.
  always_comb begin
    shifted    = bus.ram_rd_data >> {off_q, 3'b000};
    load_val_d = shifted;
    case (size_q)
      2'd0:    load_val_d = unsigned_q ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_val_d = unsigned_q ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val_d = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      unsigned_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire) begin
            if (bad || bus.cmd_write) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_error_q <= bad;
            end else begin
              state_q    <= READ;
              off_q      <= off;
              size_q     <= bus.cmd_size;
              unsigned_q <= bus.cmd_unsigned;
            end
          end
        end
        READ: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= load_val_d;
          rsp_error_q <= 1'b0;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_error = rsp_error_q;

endmodule

// File: doc/dbus_ram_bridge.md
DBUS_RAM_BRIDGE -- requirements
Module: dbus_ram_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, byte-address width of cmd_addr; RAM word address is ADDR_WIDTH-2 bits.
REQ-002 Parameter DATA_WIDTH, default 32, data width; fixed at 32; byte-mask width 4.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  CPU data-bus command valid.
REQ-006 cmd_ready  output  1  bridge can accept a command.
REQ-007 cmd_write  input  1  1 = store, 0 = load.
REQ-008 cmd_addr  input  ADDR_WIDTH  byte address.
REQ-009 cmd_size  input  2  0 byte, 1 half, 2 word, 3 reserved.
REQ-010 cmd_unsigned  input  1  load zero-extend (1) or sign-extend (0).
REQ-011 cmd_data  input  32  store data, right-aligned.
REQ-012 rsp_valid  output  1  response valid.
REQ-013 rsp_ready  input  1  CPU accepts response.
REQ-014 rsp_data  output  32  load result, extended; 0 for stores and errors.
REQ-015 rsp_error  output  1  misaligned or reserved-size command.
REQ-016 ram_wr_en / ram_wr_mask / ram_wr_addr / ram_wr_data  output  1 / 4 / ADDR_WIDTH-2 / 32  RAM write port, same clk.
REQ-017 ram_rd_en / ram_rd_addr  output  1 / ADDR_WIDTH-2  RAM read port; ram_rd_data  input  32, valid one cycle after ram_rd_en.

Function
REQ-018 FSM states IDLE, READ, RESP; cmd_ready = (state == IDLE); fire = cmd_valid & cmd_ready.
REQ-019 Error on fire if cmd_size==3, size==1 & addr[0], or size==2 & addr[1:0]!=0; error commands do not access RAM and go IDLE->RESP with rsp_error=1, rsp_data=0.
REQ-020 Legal store on fire: ram_wr_en=1 combinationally in the same cycle; ram_wr_addr=cmd_addr[ADDR_WIDTH-1:2]; IDLE->RESP with rsp_data=0, rsp_error=0.
REQ-021 Store mask: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-022 Store data replicated: byte {4{cmd_data[7:0]}}, half {2{cmd_data[15:0]}}, word cmd_data.
REQ-023 Legal load on fire: ram_rd_en=1 in the same cycle with ram_rd_addr=word address; addr[1:0], size, unsigned registered; IDLE->READ.
REQ-024 In READ: extracted lane of ram_rd_data (byte/half at addr[1:0]) extended per unsigned is registered into rsp_data; READ->RESP unconditionally after one cycle.
REQ-025 In RESP: rsp_valid=1; rsp_data/rsp_error held stable until rsp_ready; on rsp_valid & rsp_ready -> IDLE, rsp_valid drops next cycle.
REQ-026 Throughput: one command per response; new command only after response handshake; load latency fire->rsp_valid = 2 cycles, store/error = 1 cycle.
REQ-027 ram_wr_en and ram_rd_en SHALL be 0 whenever state != IDLE or cmd_valid=0; never both 1 in one cycle.
REQ-028 ram_rd_data is sampled only in READ; changes at other times have no effect.

Reset
REQ-029 resetn low asynchronously forces state=IDLE, rsp_valid=0, rsp_data=0, rsp_error=0, registered load fields 0.
REQ-030 Reset during READ or RESP discards the in-flight command; no response issued after reset release; ram_*_en=0 while resetn low.

Verification
REQ-031 Store byte 0xA5 at addr 0x0006 -> same cycle ram_wr_en=1, mask 4'b0100, wr_addr 0x0001, wr_data 0xA5A5A5A5; rsp_valid next cycle, rsp_error=0.
REQ-032 RAM word 0x0001 = 0x80FF1234; load half signed at 0x0006 -> rd_en at fire, rsp_valid 2 cycles later with rsp_data 0xFFFF80FF; unsigned -> 0x000080FF.
REQ-033 Load word at 0x0002 -> no RAM enable, rsp_error=1, rsp_data=0 one cycle after fire; cmd_size=3 behaves identically.
REQ-034 Load with rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, second cmd_valid not accepted until handshake.
REQ-035 Assert resetn low in READ -> rsp_valid stays 0, state IDLE, cmd_ready=1 one cycle after release.
REQ-036 Back-to-back store word 0xDEADBEEF to 0x0010 then load 0x0010 -> load returns 0xDEADBEEF.
